// File: rtl/alu_issue_stage_pkg.sv
// Shared types and constants for the ALU issue stage: opcode/ALU-op encodings,
// instruction field positions and the issue-entry record held in the skid buffer.
package alu_issue_stage_pkg;

    localparam int ISSUE_DATA_W = 32;
    localparam int ISSUE_IMM_W  = 17;

    // Instruction field bit positions
    localparam int OPC_MSB   = 31;
    localparam int OPC_LSB   = 27;
    localparam int RD_MSB    = 26;
    localparam int RD_LSB    = 22;
    localparam int RS_MSB    = 21;
    localparam int RS_LSB    = 17;
    localparam int RT_MSB    = 16;
    localparam int RT_LSB    = 12;
    localparam int SHAMT_MSB = 11;
    localparam int SHAMT_LSB = 7;
    localparam int ALUOP_MSB = 6;
    localparam int ALUOP_LSB = 2;

    typedef enum logic [4:0] {
        OP_RTYPE = 5'b00000,
        OP_BNE   = 5'b00010,
        OP_ADDI  = 5'b00101,
        OP_BLT   = 5'b00110,
        OP_SW    = 5'b00111,
        OP_LW    = 5'b01000
    } opcode_e;

    typedef enum logic [4:0] {
        ALU_ADD = 5'b00000,
        ALU_SUB = 5'b00001,
        ALU_AND = 5'b00010,
        ALU_OR  = 5'b00011,
        ALU_SLL = 5'b00100,
        ALU_SRA = 5'b00101
    } alu_op_e;

    typedef struct packed {
        logic [ISSUE_DATA_W-1:0] a;
        logic [ISSUE_DATA_W-1:0] b;
        alu_op_e                 ctrl;
        logic [4:0]              shamt;
        logic [4:0]              rd;
        logic                    illegal;
    } issue_entry_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Operand/control bus between register read, the issue stage and the ALU.
// master = the issue stage (transmitter); slave = the surrounding pipeline.
interface alu_issue_stage_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [DATA_W-1:0] in_rs_data;
    logic [DATA_W-1:0] in_rt_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] data_operandA;
    logic [DATA_W-1:0] data_operandB;
    logic [4:0]        ctrl_ALUopcode;
    logic [4:0]        ctrl_shiftamt;
    logic [4:0]        out_rd;
    logic              out_illegal;

    modport master (
        input  in_valid, in_instr, in_rs_data, in_rt_data, out_ready,
        output in_ready, out_valid, data_operandA, data_operandB,
               ctrl_ALUopcode, ctrl_shiftamt, out_rd, out_illegal
    );

    modport slave (
        output in_valid, in_instr, in_rs_data, in_rt_data, out_ready,
        input  in_ready, out_valid, data_operandA, data_operandB,
               ctrl_ALUopcode, ctrl_shiftamt, out_rd, out_illegal
    );

endinterface

// File: rtl/alu_issue_stage_decode.sv
// Combinational decode of one instruction plus its register values into an issue entry.
module alu_issue_decode
    import alu_issue_stage_pkg::*;
#(
    parameter int DATA_W = ISSUE_DATA_W,
    parameter int IMM_W  = ISSUE_IMM_W
) (
    input  logic [31:0]       i_instr,
    input  logic [DATA_W-1:0] i_rs_data,
    input  logic [DATA_W-1:0] i_rt_data,
    output issue_entry_t      o_entry
);

    logic [4:0]        w_opcode;
    logic [4:0]        w_aluop;
    logic [DATA_W-1:0] w_imm_sext;
    logic              w_unused_fields;

    assign w_opcode   = i_instr[OPC_MSB:OPC_LSB];
    assign w_aluop    = i_instr[ALUOP_MSB:ALUOP_LSB];
    assign w_imm_sext = {{(DATA_W-IMM_W){i_instr[IMM_W-1]}}, i_instr[IMM_W-1:0]};

    // Register indices are resolved upstream; only their data reaches this stage.
    assign w_unused_fields = ^{i_instr[RS_MSB:RS_LSB], i_instr[RT_MSB:RT_LSB]};

    always_comb begin
        // NOTE: every field gets a default before the case so no path leaves it unassigned (no latches).
        o_entry    = '0;
        o_entry.rd = i_instr[RD_MSB:RD_LSB];
        case (w_opcode)
            OP_RTYPE: begin
                o_entry.a     = i_rs_data;
                o_entry.b     = i_rt_data;
                o_entry.shamt = i_instr[SHAMT_MSB:SHAMT_LSB];
                if (w_aluop <= ALU_SRA) begin
                    o_entry.ctrl = alu_op_e'(w_aluop);
                end else begin
                    o_entry.ctrl    = ALU_ADD;
                    o_entry.illegal = 1'b1;
                end
            end
            OP_ADDI, OP_SW, OP_LW: begin
                o_entry.a    = i_rs_data;
                o_entry.b    = w_imm_sext;
                o_entry.ctrl = ALU_ADD;
            end
            // Branches compare the rd register (delivered on the rs read port) against rt.
            OP_BNE, OP_BLT: begin
                o_entry.a    = i_rs_data;
                o_entry.b    = i_rt_data;
                o_entry.ctrl = ALU_SUB;
            end
            default: begin
                o_entry.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes accepted instructions into a main register M that drives
// the ALU, with a skid register S so in_ready never depends combinationally on out_ready.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int DATA_W = ISSUE_DATA_W,
    parameter int IMM_W  = ISSUE_IMM_W
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               flush,
    alu_issue_stage_if.master  bus
);

    issue_entry_t w_decoded;
    issue_entry_t r_m;
    issue_entry_t r_s;
    logic         r_m_valid;
    logic         r_s_valid;
    logic         w_accept;
    logic         w_issue;
    logic         w_m_free;

    alu_issue_decode #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W)
    ) u_decode (
        .i_instr   (bus.in_instr),
        .i_rs_data (bus.in_rs_data),
        .i_rt_data (bus.in_rt_data),
        .o_entry   (w_decoded)
    );

    assign w_accept = bus.in_valid && !r_s_valid;
    assign w_issue  = r_m_valid && bus.out_ready;
    // M can take a new entry when it is empty or leaving this cycle.
    assign w_m_free = !r_m_valid || w_issue;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_m_valid <= 1'b0;
            r_s_valid <= 1'b0;
            r_m       <= '0;
        end else if (flush) begin
            r_m_valid <= 1'b0;
            r_s_valid <= 1'b0;
        end else if (w_m_free) begin
            // NOTE: non-blocking assignments so every branch sees the pre-edge r_s/r_m values.
            if (r_s_valid) begin
                r_m       <= r_s;
                r_m_valid <= 1'b1;
                r_s_valid <= 1'b0;
            end else if (w_accept) begin
                r_m       <= w_decoded;
                r_m_valid <= 1'b1;
            end else begin
                r_m_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_s_valid <= 1'b1;
        end
    end

    // NOTE: the skid payload is never observed while r_s_valid is low, so it carries no reset.
    always_ff @(posedge clock) begin
        if (!flush && !w_m_free && w_accept) begin
            r_s <= w_decoded;
        end
    end

    assign bus.in_ready       = !r_s_valid;
    assign bus.out_valid      = r_m_valid;
    assign bus.data_operandA  = r_m.a;
    assign bus.data_operandB  = r_m.b;
    assign bus.ctrl_ALUopcode = r_m.ctrl;
    assign bus.ctrl_shiftamt  = r_m.shamt;
    assign bus.out_rd         = r_m.rd;
    assign bus.out_illegal    = r_m.illegal;

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Transmitter side of the ALU operand/control interface. Accepts one decoded-register instruction per handshake and produces registered data_operandA, data_operandB, ctrl_ALUopcode and ctrl_shiftamt that drive the combinational ALU directly.
- Sits between the register-read stage and the execute stage.
- Contains a 2-entry skid buffer so upstream ready never combinationally depends on downstream ready.

Parameters:
- DATA_W, 32, operand width.
- IMM_W, 17, immediate field width (instr[16:0]); sign-extended to DATA_W.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  reset, asynchronous and active-low.
- flush  in  1  synchronous kill of all buffered entries.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept an entry.
- in_instr  in  32  instruction: opcode[31:27], rd[26:22], rs[21:17], rt[16:12], shamt[11:7], aluop[6:2], imm[16:0].
- in_rs_data  in  DATA_W  value read for rs.
- in_rt_data  in  DATA_W  value read for rt.
- out_valid  out  1  issued entry valid.
- out_ready  in  1  execute stage accepts the entry.
- data_operandA  out  DATA_W  ALU operand A.
- data_operandB  out  DATA_W  ALU operand B.
- ctrl_ALUopcode  out  5  ALU op: 00000 add, 00001 sub, 00010 and, 00011 or, 00100 sll, 00101 sra.
- ctrl_shiftamt  out  5  shift amount.
- out_rd  out  5  destination register (passthrough).
- out_illegal  out  1  entry carried an unsupported opcode or aluop.

Behaviour:
- Reset, asynchronous on reset_n low: both buffer entries invalid; out_valid=0; all data and ctrl outputs 0; in_ready=1 from the first cycle after release.
- Decode (combinational on input, registered on accept):
  - opcode 00000 (R-type): A=rs_data, B=rt_data, ctrl=aluop, shamt=shamt. aluop > 00101 gives ctrl=00000 and illegal=1.
  - opcode 00101 addi, 00111 sw, 01000 lw: A=rs_data, B=sext(imm), ctrl=00000, shamt=0.
  - opcode 00010 bne, 00110 blt: A=rd-register data supplied on in_rs_data, B=in_rt_data, ctrl=00001, shamt=0.
  - Any other opcode: A=B=0, ctrl=00000, shamt=0, illegal=1.
- Handshake:
  - Accept when in_valid&&in_ready.
  - Issue when out_valid&&out_ready.
  - Outputs are held stable while out_valid&&!out_ready.
- Buffer: main register M (drives outputs) plus skid register S.
  - in_ready = !S.valid. This is a registered value with no combinational path from out_ready.
  - Accept with M empty, or M issuing this cycle with S empty: entry goes to M.
  - Accept while M is stalled: entry goes to S.
  - M issues while S is valid: S moves to M, and S becomes empty.
  - Accept and issue in the same cycle with S valid cannot occur, because in_ready=0.
- Throughput: 1 entry/cycle when out_ready is held high. Latency is 1 cycle from accept to out_valid.
- Ordering is strictly FIFO. No entry is lost or duplicated.
- flush: next edge clears M.valid and S.valid. Any same-cycle accept is discarded. Data registers may keep stale values, but out_valid=0. flush overrides everything except reset.
- Reset mid-stall: all entries are dropped immediately and out_valid goes to 0 asynchronously.
- Width rule: sext replicates imm[16] into bits [DATA_W-1:17].

Decomposition:
- Shared package holds:
  - opcode constants (OP_RTYPE, OP_ADDI, OP_SW, OP_LW, OP_BNE, OP_BLT);
  - ALU op constants (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLL, ALU_SRA);
  - field bit positions;
  - the issue-entry struct {A, B, ctrl, shamt, rd, illegal}.
- One sub-module is natural: alu_issue_decode, purely combinational, mapping instr and register data to an entry. The top holds the M/S registers and the handshake.

Test Plan:
- R-type add, instr aluop=00000 with rs_data=5 and rt_data=7, out_ready=1 -> next cycle out_valid=1, A=5, B=7, ctrl=00000; ALU result 12.
- addi with imm=0x1FFFF and rs_data=10 -> B=0xFFFFFFFF, ctrl=00000; sll with shamt=31 and aluop=00100 -> ctrl_shiftamt=31, ctrl=00100.
- Backpressure: 3 back-to-back entries, out_ready=0 from cycle 2 -> in_ready drops after the 2nd accept, outputs hold entry 1; raise out_ready -> entries 1, 2, 3 issue in order on consecutive cycles.
- Illegal cases: opcode 11111, and R-type aluop=00111 -> out_illegal=1, ctrl=00000, A=B=0 for the opcode case.
- flush with M and S both full -> next cycle out_valid=0, in_ready=1; a new entry then issues normally.
- Assert reset_n low while stalled with 2 entries -> out_valid=0 with no clock edge; after release, in_ready=1 and no stale entry is issued.
